spi_prog_bridge: RTL and testbench
==================================

# spi_prog_bridge

Parametrised SPI-slave programming and mailbox bridge between an external SPI host and the RISC-V core.
- Boot mode: holds the CPU in reset and burst-writes instruction memory over SPI, with configurable instruction width and address depth.
- Run mode: releases the CPU and provides byte mailboxes in both directions, host-to-CPU and CPU-to-host through a TX FIFO.
- All SPI pins are oversampled in the clk domain, so the block has a single clock domain.

## Interface
Parameters:
- INSTR_W, 32, instruction width in bits; multiple of 8, 8..64.
- ADDR_W, 4, imem address width; depth is 2^ADDR_W words, ADDR_W ≤ 8.
- TX_DEPTH, 4, CPU-to-host FIFO depth in bytes; power of 2, ≥ 2.

Ports:
- clk  in  1  system clock; must be ≥ 8× sclk.
- rst_n  in  1  reset: synchronous, active-low.
- sclk, cs, mosi  in  1 each  SPI mode 0, MSB first; cs is active-low.
- miso  out  1  SPI data out.
- mode  out  1  0 = boot, 1 = run.
- cpu_rst_n  out  1  CPU reset, active-low.
- cmd_error  out  1  sticky invalid-command flag.
- imem_wr_en  out  1  one-cycle imem write strobe.
- prog_addr  out  ADDR_W  imem write address.
- prog_instr  out  INSTR_W  imem write data.
- rx_data  out  8  host-to-CPU byte.
- rx_valid  out  1  one-cycle pulse qualifying rx_data.
- tx_data  in  8  CPU-to-host byte.
- tx_valid  in  1  CPU push request.
- tx_ready  out  1  FIFO not full.

## Operation
Pin front end:
- sclk, cs and mosi each pass through a 2-flop synchroniser.
- sclk rising edge: sample mosi into the shift register.
- sclk falling edge: shift miso.
- A byte completes on the 8th sampled bit.

Frames and FSM:
- A frame starts at a cs falling edge; its first byte is the command.
- States: IDLE, CMD, ADDR, DATA, STATUS, TXRD, RXFWD, IGNORE.
- cs rising edge in any state: go to IDLE and discard any partial byte and partial word.

Commands valid in boot mode:
- 0xC0 WRITE
  - Next byte is the start address (low ADDR_W bits used) → DATA.
  - Each following group of INSTR_W/8 bytes, least-significant byte first, forms one word.
  - On the word's last byte: prog_instr = word, prog_addr = current address, imem_wr_en pulses, address increments mod 2^ADDR_W.
  - The burst continues until cs rises.
- 0xC1 STATUS: the next miso byte is {mode, cmd_error, tx_full, tx_empty, next_addr[3:0] zero-extended}.
- 0xC6 RUN: mode←1, cpu_rst_n←1.

Commands valid in run mode:
- 0xC8 TXRD: each following miso byte pops the TX FIFO; if the FIFO is empty, send 0x00 and do not pop.
- 0xC9 SEND: each following complete byte drives rx_data and pulses rx_valid.
- 0xC1 STATUS behaves as in boot mode.

Valid in either mode:
- 0xC7 BOOT: mode←0, cpu_rst_n←0, next_addr←0.

Any other command byte: cmd_error←1 (cleared only by rst_n) → IGNORE until cs rises.

miso:
- Loaded at byte boundaries with the byte for the next slot.
- Drives 0 in command, address and data slots and whenever cs is high.

TX FIFO:
- Push when tx_valid && tx_ready.
- tx_ready = !full, evaluated before any same-cycle pop.
- A pop and a push in the same cycle on a non-full FIFO are both honoured.
- When empty, a same-cycle push does not feed that cycle's pop.

## Timing
Reset values:
- mode=0, cpu_rst_n=0, cmd_error=0.
- imem_wr_en=0, prog_addr=0, prog_instr=0.
- rx_data=0, rx_valid=0.
- tx_ready=1, miso=0.
- FIFO empty, next_addr=0, FSM IDLE.

Latencies and ordering:
- Byte completion is detected 3 clk after the 8th sclk rise at the pin.
- imem_wr_en, rx_valid, and the mode/cpu_rst_n updates occur 1 clk after byte completion.
- imem_wr_en and rx_valid are exactly 1 clk wide; prog_addr and prog_instr hold until the next write.
- miso updates ≤ 3 clk after an sclk fall at the pin.
- The first bit of a loaded byte is valid before the slot's first sclk rise.
- Mode changes take effect for the next frame's command decode.

rst_n mid-frame:
- All state returns to reset values.
- The FSM stays in IDLE until a fresh cs falling edge, so an in-flight frame is ignored.

## Test plan
- Boot write burst, INSTR_W=32:
  - Stimulus: frame C0 0E, then words 0x00A00093 and 0x00100113 (LSB first).
  - Required: writes addr 0xE = 0x00A00093 and addr 0xF = 0x00100113.
  - Stimulus: a third word.
  - Required: written at addr 0x0 (wrap).
- Partial word: C0 03 AA BB, then cs rises.
  - Required: no imem_wr_en.
  - Required: the next STATUS returns next_addr = 3.
- Mode switch:
  - C6: mode=1, cpu_rst_n=1.
  - C9 5A 3C: rx_valid pulses twice, with rx_data = 0x5A then 0x3C.
  - C7: mode=0, cpu_rst_n=0.
- TX FIFO, TX_DEPTH=4:
  - Push 5 bytes 11..55: tx_ready low after 4; byte 55 is not accepted.
  - C8 plus 5 dummy bytes: miso returns 11 22 33 44 00.
- Bad command:
  - 0x7E: cmd_error=1, and the rest of the frame is ignored.
  - cmd_error persists across frames until rst_n.
  - rst_n asserted mid-burst: all outputs return to reset values.

Source files
------------

// File: rtl/spi_prog_bridge_if.sv
// Bundle of the SPI pins, imem programming port and CPU mailbox of spi_prog_bridge.
// slave modport: the bridge itself; master modport: the SPI host / CPU / imem side.
// Latency and backpressure live in the bridge; this file only groups signals.
interface spi_prog_bridge_if #(
   parameter int INSTR_W = 32,
   parameter int ADDR_W  = 4
);
   logic               sclk;
   logic               cs;
   logic               mosi;
   logic               miso;
   logic               mode;
   logic               cpu_rst_n;
   logic               cmd_error;
   logic               imem_wr_en;
   logic [ADDR_W-1:0]  prog_addr;
   logic [INSTR_W-1:0] prog_instr;
   logic [7:0]         rx_data;
   logic               rx_valid;
   logic [7:0]         tx_data;
   logic               tx_valid;
   logic               tx_ready;

   modport slave (
      input  sclk, cs, mosi, tx_data, tx_valid,
      output miso, mode, cpu_rst_n, cmd_error, imem_wr_en, prog_addr, prog_instr,
             rx_data, rx_valid, tx_ready
   );

   modport master (
      output sclk, cs, mosi, tx_data, tx_valid,
      input  miso, mode, cpu_rst_n, cmd_error, imem_wr_en, prog_addr, prog_instr,
             rx_data, rx_valid, tx_ready
   );
endinterface

// File: rtl/spi_prog_bridge.sv
// SPI-slave (mode 0) bridge: boot-mode imem burst programming, run-mode byte mailboxes.
// Latency: byte seen 3 clk after 8th sclk rise, write/rx/mode strobes 1 clk later.
// Backpressure: none on SPI; CPU pushes gated by tx_ready (TX FIFO not full).
// Ports: clk, rst_n (sync, active-low), bus (spi_prog_bridge_if.slave) with all pins.
module spi_prog_bridge #(
   parameter int INSTR_W  = 32,
   parameter int ADDR_W   = 4,
   parameter int TX_DEPTH = 4
) (
   input logic             clk,
   input logic             rst_n,
   spi_prog_bridge_if.slave bus
);
   localparam int NB = INSTR_W / 8;
   localparam int PW = $clog2(TX_DEPTH);

   localparam logic [7:0] CMD_WRITE  = 8'hC0;
   localparam logic [7:0] CMD_STATUS = 8'hC1;
   localparam logic [7:0] CMD_RUN    = 8'hC6;
   localparam logic [7:0] CMD_BOOT   = 8'hC7;
   localparam logic [7:0] CMD_TXRD   = 8'hC8;
   localparam logic [7:0] CMD_SEND   = 8'hC9;

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_DATA, S_STATUS, S_TXRD, S_RXFWD, S_IGNORE
   } state_t;

   state_t             state;
   logic [2:0]         sclk_sy, cs_sy;   // [0],[1] synchroniser, [2] previous value
   logic [1:0]         mosi_sy;
   logic               sclk_rise, sclk_fall, cs_rise, cs_fall;
   logic [2:0]         bit_cnt;
   logic [6:0]         rx_sh;
   logic               byte_vld;
   logic [7:0]         byte_dat;
   logic [2:0]         byte_idx;
   logic [INSTR_W-1:0] word_buf, word_next;
   logic [ADDR_W-1:0]  next_addr;
   logic [7:0]         tx_sh, next_tx, tx_byte, status_byte;
   logic               skip_fall, load_en, pop_req, push, pop;
   logic [7:0]         fifo_mem [TX_DEPTH];
   logic [PW:0]        wr_ptr, rd_ptr;
   logic               tx_full, tx_empty;

   assign sclk_rise = sclk_sy[1] & ~sclk_sy[2];
   assign sclk_fall = ~sclk_sy[1] & sclk_sy[2];
   assign cs_rise   = cs_sy[1] & ~cs_sy[2];
   assign cs_fall   = ~cs_sy[1] & cs_sy[2];

   // cs sync flops reset low: if cs is already low when reset releases no fall is
   // seen, so a frame in flight is ignored until cs goes high and low again.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sclk_sy <= '0;
         cs_sy   <= '0;
         mosi_sy <= '0;
      end else begin
         sclk_sy <= {sclk_sy[1:0], bus.sclk};
         cs_sy   <= {cs_sy[1:0], bus.cs};
         mosi_sy <= {mosi_sy[0], bus.mosi};
      end
   end

   // Byte assembly on synchronised sclk rises; byte_vld is a one-cycle strobe.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bit_cnt  <= '0;
         rx_sh    <= '0;
         byte_vld <= 1'b0;
         byte_dat <= '0;
      end else if (state == S_IDLE || cs_rise) begin
         bit_cnt  <= '0;
         byte_vld <= 1'b0;
      end else begin
         byte_vld <= 1'b0;
         if (sclk_rise) begin
            rx_sh   <= {rx_sh[5:0], mosi_sy[1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               byte_vld <= 1'b1;
               byte_dat <= {rx_sh, mosi_sy[1]};
            end
         end
      end
   end

   // TX FIFO; full/empty come from registered pointers, so tx_ready is judged
   // before any same-cycle pop and an empty FIFO never forwards a same-cycle push.
   assign tx_empty     = (wr_ptr == rd_ptr);
   assign tx_full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign bus.tx_ready = ~tx_full;
   assign push         = bus.tx_valid & ~tx_full;
   assign pop          = pop_req & load_en & ~tx_empty;
   assign tx_byte      = tx_empty ? 8'h00 : fifo_mem[rd_ptr[PW-1:0]];

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr[PW-1:0]] <= bus.tx_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
      end
   end

   // Byte to present in the next miso slot, chosen at the byte boundary.
   assign status_byte = {bus.mode, bus.cmd_error, tx_full, tx_empty, 4'(next_addr)};
   assign load_en     = byte_vld & ~cs_sy[1] & (state != S_IDLE);

   always_comb begin
      next_tx = 8'h00;
      pop_req = 1'b0;
      case (state)
         S_CMD: begin
            if (byte_dat == CMD_STATUS) begin
               next_tx = status_byte;
            end else if (bus.mode && byte_dat == CMD_TXRD) begin
               next_tx = tx_byte;
               pop_req = 1'b1;
            end
         end
         S_TXRD: begin
            next_tx = tx_byte;
            pop_req = 1'b1;
         end
         default: ;
      endcase
   end

   // The load lands before the fall that ends the current byte; that fall must
   // not shift, otherwise the fresh MSB would be lost.
   always_ff @(posedge clk) begin
      if (!rst_n || cs_sy[1]) begin
         tx_sh     <= '0;
         skip_fall <= 1'b0;
      end else if (load_en) begin
         tx_sh     <= next_tx;
         skip_fall <= 1'b1;
      end else if (sclk_fall) begin
         if (skip_fall) skip_fall <= 1'b0;
         else           tx_sh     <= {tx_sh[6:0], 1'b0};
      end
   end
   assign bus.miso = tx_sh[7];

   always_comb begin
      word_next = word_buf;
      word_next[{byte_idx, 3'b000} +: 8] = byte_dat;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         bus.mode       <= 1'b0;
         bus.cpu_rst_n  <= 1'b0;
         bus.cmd_error  <= 1'b0;
         bus.imem_wr_en <= 1'b0;
         bus.prog_addr  <= '0;
         bus.prog_instr <= '0;
         bus.rx_data    <= '0;
         bus.rx_valid   <= 1'b0;
         next_addr      <= '0;
         byte_idx       <= '0;
         word_buf       <= '0;
      end else begin
         bus.imem_wr_en <= 1'b0;
         bus.rx_valid   <= 1'b0;
         if (cs_rise) begin
            state    <= S_IDLE;
            byte_idx <= '0;
            word_buf <= '0;
         end else if (state == S_IDLE) begin
            if (cs_fall) state <= S_CMD;
         end else if (byte_vld) begin
            case (state)
               S_CMD: begin
                  state <= S_IGNORE;
                  if (byte_dat == CMD_STATUS) begin
                     state <= S_STATUS;
                  end else if (byte_dat == CMD_BOOT) begin
                     bus.mode      <= 1'b0;
                     bus.cpu_rst_n <= 1'b0;
                     next_addr     <= '0;
                  end else if (!bus.mode && byte_dat == CMD_WRITE) begin
                     state <= S_ADDR;
                  end else if (!bus.mode && byte_dat == CMD_RUN) begin
                     bus.mode      <= 1'b1;
                     bus.cpu_rst_n <= 1'b1;
                  end else if (bus.mode && byte_dat == CMD_TXRD) begin
                     state <= S_TXRD;
                  end else if (bus.mode && byte_dat == CMD_SEND) begin
                     state <= S_RXFWD;
                  end else begin
                     bus.cmd_error <= 1'b1;
                  end
               end
               S_ADDR: begin
                  next_addr <= byte_dat[ADDR_W-1:0];
                  byte_idx  <= '0;
                  state     <= S_DATA;
               end
               S_DATA: begin
                  if (byte_idx == 3'(NB-1)) begin
                     bus.prog_instr <= word_next;
                     bus.prog_addr  <= next_addr;
                     bus.imem_wr_en <= 1'b1;
                     next_addr      <= next_addr + ADDR_W'(1);
                     byte_idx       <= '0;
                  end else begin
                     word_buf <= word_next;
                     byte_idx <= byte_idx + 3'd1;
                  end
               end
               S_RXFWD: begin
                  bus.rx_data  <= byte_dat;
                  bus.rx_valid <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_spi_prog_bridge.sv
// Testbench for spi_prog_bridge: SPI host model plus scoreboard monitors for
// imem writes, rx mailbox strobes and every miso byte.
module tb_spi_prog_bridge;
   localparam int HALF = 80;   // half sclk period = 8 clk periods

   typedef struct {
      logic [3:0]  addr;
      logic [31:0] instr;
   } wr_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   wr_t        exp_wr[$];
   logic [7:0] exp_rx[$];
   logic [7:0] exp_miso[$];

   spi_prog_bridge_if #(.INSTR_W(32), .ADDR_W(4)) bus ();

   spi_prog_bridge #(.INSTR_W(32), .ADDR_W(4), .TX_DEPTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Output scoreboard: pops an expectation each time a strobe is presented.
   always @(negedge clk) begin
      if (bus.imem_wr_en === 1'b1) begin
         if (exp_wr.size() == 0) begin
            check("unexpected imem_wr_en", 1, 0);
         end else begin
            wr_t w;
            w = exp_wr.pop_front();
            check("prog_addr", 64'(bus.prog_addr), 64'(w.addr));
            check("prog_instr", 64'(bus.prog_instr), 64'(w.instr));
         end
      end
      if (bus.rx_valid === 1'b1) begin
         if (exp_rx.size() == 0) begin
            check("unexpected rx_valid", 1, 0);
         end else begin
            logic [7:0] e;
            e = exp_rx.pop_front();
            check("rx_data", 64'(bus.rx_data), 64'(e));
         end
      end
   end

   // miso monitor: assembles each byte on sclk rises while cs is low.
   initial begin : miso_mon
      logic [7:0] sh;
      logic [7:0] e;
      int n;
      n  = 0;
      sh = 8'h00;
      forever begin
         @(posedge bus.sclk or posedge bus.cs);
         if (bus.cs !== 1'b0) begin
            n = 0;
         end else begin
            sh = {sh[6:0], bus.miso};
            n++;
            if (n == 8) begin
               n = 0;
               if (exp_miso.size() == 0) begin
                  check("unexpected miso byte", 1, 0);
               end else begin
                  e = exp_miso.pop_front();
                  check("miso byte", 64'(sh), 64'(e));
               end
            end
         end
      end
   end

   initial begin : watchdog
      #3000000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors + 1);
      $fatal(1, "timeout");
   end

   task automatic frame_start();
      @(negedge clk);
      bus.cs = 1'b0;
      #(HALF);
   endtask

   task automatic frame_end();
      #(HALF);
      bus.cs   = 1'b1;
      bus.mosi = 1'b0;
      #(4*HALF);
   endtask

   task automatic xfer(input logic [7:0] mo, input logic [7:0] exp_mi);
      exp_miso.push_back(exp_mi);
      for (int i = 7; i >= 0; i--) begin
         bus.mosi = mo[i];
         #(HALF);
         bus.sclk = 1'b1;
         #(HALF);
         bus.sclk = 1'b0;
      end
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int b = 0; b < 4; b++) xfer(w[8*b +: 8], 8'h00);
   endtask

   task automatic push_tx(input logic [7:0] d, input logic exp_rdy);
      @(negedge clk);
      check("tx_ready at push", 64'(bus.tx_ready), 64'(exp_rdy));
      bus.tx_data  = d;
      bus.tx_valid = 1'b1;
      @(negedge clk);
      bus.tx_valid = 1'b0;
   endtask

   task automatic status_frame(input logic [7:0] exp_status);
      frame_start();
      xfer(8'hC1, 8'h00);
      xfer(8'h00, exp_status);
      frame_end();
   endtask

   task automatic check_reset_outputs();
      check("mode rst", 64'(bus.mode), 0);
      check("cpu_rst_n rst", 64'(bus.cpu_rst_n), 0);
      check("cmd_error rst", 64'(bus.cmd_error), 0);
      check("imem_wr_en rst", 64'(bus.imem_wr_en), 0);
      check("prog_addr rst", 64'(bus.prog_addr), 0);
      check("prog_instr rst", 64'(bus.prog_instr), 0);
      check("rx_data rst", 64'(bus.rx_data), 0);
      check("rx_valid rst", 64'(bus.rx_valid), 0);
      check("tx_ready rst", 64'(bus.tx_ready), 1);
      check("miso rst", 64'(bus.miso), 0);
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      rst_n        = 1'b0;
      bus.cs       = 1'b1;
      bus.sclk     = 1'b0;
      bus.mosi     = 1'b0;
      bus.tx_data  = 8'h00;
      bus.tx_valid = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_outputs();

      // Boot burst from 0xE: two words then a third wrapping to address 0.
      exp_wr.push_back('{4'hE, 32'h00A00093});
      exp_wr.push_back('{4'hF, 32'h00100113});
      exp_wr.push_back('{4'h0, 32'hDEADBEEF});
      frame_start();
      xfer(8'hC0, 8'h00);
      xfer(8'h0E, 8'h00);
      send_word(32'h00A00093);
      send_word(32'h00100113);
      send_word(32'hDEADBEEF);
      frame_end();
      check("writes drained after burst", 64'(exp_wr.size()), 0);
      status_frame(8'h11);   // boot, no error, FIFO empty, next_addr 1

      // Partial word is discarded; address register still takes the start address.
      frame_start();
      xfer(8'hC0, 8'h00);
      xfer(8'h03, 8'h00);
      xfer(8'hAA, 8'h00);
      xfer(8'hBB, 8'h00);
      frame_end();
      status_frame(8'h13);

      // Switch to run mode.
      frame_start();
      xfer(8'hC6, 8'h00);
      frame_end();
      check("mode after RUN", 64'(bus.mode), 1);
      check("cpu_rst_n after RUN", 64'(bus.cpu_rst_n), 1);

      // Host-to-CPU mailbox.
      exp_rx.push_back(8'h5A);
      exp_rx.push_back(8'h3C);
      frame_start();
      xfer(8'hC9, 8'h00);
      xfer(8'h5A, 8'h00);
      xfer(8'h3C, 8'h00);
      frame_end();
      check("rx drained", 64'(exp_rx.size()), 0);

      // CPU-to-host FIFO: fifth byte refused.
      push_tx(8'h11, 1'b1);
      push_tx(8'h22, 1'b1);
      push_tx(8'h33, 1'b1);
      push_tx(8'h44, 1'b1);
      push_tx(8'h55, 1'b0);
      check("tx_ready when full", 64'(bus.tx_ready), 0);
      status_frame(8'hA3);   // run, no error, full, not empty, next_addr 3
      frame_start();
      xfer(8'hC8, 8'h00);
      xfer(8'h00, 8'h11);
      xfer(8'h00, 8'h22);
      xfer(8'h00, 8'h33);
      xfer(8'h00, 8'h44);
      xfer(8'h00, 8'h00);
      frame_end();
      check("tx_ready after drain", 64'(bus.tx_ready), 1);

      // Back to boot mode.
      frame_start();
      xfer(8'hC7, 8'h00);
      frame_end();
      check("mode after BOOT", 64'(bus.mode), 0);
      check("cpu_rst_n after BOOT", 64'(bus.cpu_rst_n), 0);
      status_frame(8'h10);

      // Bad command: remainder of the frame (a RUN byte) must be ignored.
      frame_start();
      xfer(8'h7E, 8'h00);
      xfer(8'hC6, 8'h00);
      frame_end();
      check("cmd_error after bad cmd", 64'(bus.cmd_error), 1);
      check("mode unchanged after bad cmd", 64'(bus.mode), 0);
      status_frame(8'h50);
      check("cmd_error sticky", 64'(bus.cmd_error), 1);

      // Reset in the middle of a burst; the rest of the frame is ignored.
      frame_start();
      xfer(8'hC0, 8'h00);
      xfer(8'h05, 8'h00);
      xfer(8'h11, 8'h00);
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_outputs();
      for (int i = 0; i < 5; i++) xfer(8'(8'h22 + 8'(i) * 8'h11), 8'h00);
      frame_end();
      check("cmd_error after mid-frame reset", 64'(bus.cmd_error), 0);
      status_frame(8'h10);

      #(4*HALF);
      check("writes drained", 64'(exp_wr.size()), 0);
      check("rx drained at end", 64'(exp_rx.size()), 0);
      check("miso drained", 64'(exp_miso.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
